fetch_stage: RTL and testbench

Fetch stage of the Y86-64 pipeline plus its F and D pipeline registers. Consumes the selected fetch address `next_PC` from the PC-select logic each cycle. Drives the 10-byte instruction window address to instruction memory and splits the returned bytes into icode/ifun/rA/rB/valC/valP. Computes the predicted next PC (`F_predPC`, fed back to PC select) and latches the fetched instruction into the D register under hazard-unit stall/bubble control.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus between PC select / imem / hazard unit and the fetch stage
interface fetch_if;
    logic [63:0] next_PC;
    logic [79:0] imem_data;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic [63:0] imem_addr;
    logic [63:0] F_predPC;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    modport master (
        output next_PC, imem_data, F_stall, D_stall, D_bubble,
        input  imem_addr, F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
    );

    modport slave (
        input  next_PC, imem_data, F_stall, D_stall, D_bubble,
        output imem_addr, F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 fetch with split/predict logic, F register and D register
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.slave bus
);
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;
    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] R_NONE = 4'hF;

    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic        w_valid;
    logic        w_need_regids;
    logic        w_need_valc;
    logic        w_adr_err;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [63:0] w_valc;
    logic [63:0] w_valp;
    logic [63:0] w_pred;
    logic [2:0]  w_stat;
    logic [3:0]  w_f_icode;
    logic [3:0]  w_f_ifun;

    logic [63:0] r_pred_pc;
    logic [2:0]  r_d_stat;
    logic [3:0]  r_d_icode;
    logic [3:0]  r_d_ifun;
    logic [3:0]  r_d_ra;
    logic [3:0]  r_d_rb;
    logic [63:0] r_d_valc;
    logic [63:0] r_d_valp;

    assign bus.imem_addr = bus.next_PC;

    assign w_icode       = bus.imem_data[7:4];
    assign w_ifun        = bus.imem_data[3:0];
    assign w_valid       = w_icode <= 4'hB;
    assign w_need_regids = w_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    assign w_need_valc   = w_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    assign w_adr_err     = bus.next_PC >= 64'(IMEM_BYTES);

    // Split the instruction window into register ids, constant and fall-through PC
    always_comb begin
        w_ra   = w_need_regids ? bus.imem_data[15:12] : R_NONE;
        w_rb   = w_need_regids ? bus.imem_data[11:8]  : R_NONE;
        w_valc = !w_need_valc ? 64'd0 :
                 w_need_regids ? bus.imem_data[79:16] : bus.imem_data[71:8];
        w_valp = bus.next_PC + 64'd1 + {63'd0, w_need_regids} + (w_need_valc ? 64'd8 : 64'd0);
    end

    // Status, nop substitution on bad addresses, and next-PC prediction
    always_comb begin
        w_stat    = w_adr_err ? S_ADR :
                    !w_valid ? S_INS :
                    (w_icode == I_HALT) ? S_HLT : S_AOK;
        w_f_icode = w_adr_err ? I_NOP : w_icode;
        w_f_ifun  = w_adr_err ? 4'h0 : w_ifun;
        w_pred    = (!w_adr_err && (w_icode == I_JXX || w_icode == I_CALL)) ? w_valc : w_valp;
    end

    // F register: predicted PC, held while fetch is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pred_pc <= RESET_PC;
        else if (!bus.F_stall)
            r_pred_pc <= w_pred;
    end

    // D register: stall holds, bubble injects a nop, otherwise latch the fetched fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_stat  <= S_AOK;
            r_d_icode <= I_NOP;
            r_d_ifun  <= 4'h0;
            r_d_ra    <= R_NONE;
            r_d_rb    <= R_NONE;
            r_d_valc  <= 64'd0;
            r_d_valp  <= 64'd0;
        end else if (bus.D_stall) begin
            r_d_stat  <= r_d_stat;
        end else if (bus.D_bubble) begin
            r_d_stat  <= S_AOK;
            r_d_icode <= I_NOP;
            r_d_ifun  <= 4'h0;
            r_d_ra    <= R_NONE;
            r_d_rb    <= R_NONE;
            r_d_valc  <= 64'd0;
            r_d_valp  <= 64'd0;
        end else begin
            r_d_stat  <= w_stat;
            r_d_icode <= w_f_icode;
            r_d_ifun  <= w_f_ifun;
            r_d_ra    <= w_ra;
            r_d_rb    <= w_rb;
            r_d_valc  <= w_valc;
            r_d_valp  <= w_valp;
        end
    end

    assign bus.F_predPC = r_pred_pc;
    assign bus.D_stat   = r_d_stat;
    assign bus.D_icode  = r_d_icode;
    assign bus.D_ifun   = r_d_ifun;
    assign bus.D_rA     = r_d_ra;
    assign bus.D_rB     = r_d_rb;
    assign bus.D_valC   = r_d_valc;
    assign bus.D_valP   = r_d_valp;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed checks of fetch_stage plus stall/bubble/reset sequences
module tb_fetch_stage;
    typedef struct {
        logic [63:0] pc;
        logic [79:0] data;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] pred;
    } vec_t;

    localparam int NV = 11;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    vec_t v [NV];
    vec_t nop_e;

    fetch_if bus ();

    fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_d(input string tag, input vec_t e);
        check({tag, ".stat"},  64'(bus.D_stat),  64'(e.stat));
        check({tag, ".icode"}, 64'(bus.D_icode), 64'(e.icode));
        check({tag, ".ifun"},  64'(bus.D_ifun),  64'(e.ifun));
        check({tag, ".rA"},    64'(bus.D_rA),    64'(e.ra));
        check({tag, ".rB"},    64'(bus.D_rB),    64'(e.rb));
        check({tag, ".valC"},  bus.D_valC,       e.valc);
        check({tag, ".valP"},  bus.D_valP,       e.valp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [79:0] data,
                         input logic fs, input logic ds, input logic db);
        bus.next_PC   = pc;
        bus.imem_data = data;
        bus.F_stall   = fs;
        bus.D_stall   = ds;
        bus.D_bubble  = db;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        clk     = 1'b0;
        rst_n   = 1'b1;
        nop_e   = '{64'h0, 80'h0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0};
        //          pc                      data                               st  ic   if   rA   rB   valC                    valP                    pred
        v[0]  = '{64'h0,                  80'h0000_0000_0000_000A_F230, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'hA,   64'hA,   64'hA};
        v[1]  = '{64'h20,                 80'h0000_0000_0000_0001_0070, 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29,  64'h100};
        v[2]  = '{64'h30,                 80'h0000_0000_0000_0000_4080, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h40,  64'h39,  64'h40};
        v[3]  = '{64'h40,                 80'h0000_0000_0000_0000_00C0, 3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0,   64'h41,  64'h41};
        v[4]  = '{64'h400,                80'h0,                        3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,   64'h401, 64'h401};
        v[5]  = '{64'h60,                 80'h0,                        3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'h61,  64'h61};
        v[6]  = '{64'h100,                80'h0000_0000_0000_0000_3420, 3'd1, 4'h2, 4'h0, 4'h3, 4'h4, 64'h0,   64'h102, 64'h102};
        v[7]  = '{64'h3FF,                80'h0000_0000_0000_0000_0010, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,   64'h400, 64'h400};
        v[8]  = '{64'hFFFF_FFFF_FFFF_FFF8, 80'h0000_0000_0000_000A_F230, 3'd3, 4'h1, 4'h0, 4'hF, 4'h2, 64'hA,   64'h2,   64'h2};
        v[9]  = '{64'h70,                 80'h0000_0000_0000_0000_0090, 3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0,   64'h71,  64'h71};
        v[10] = '{64'h50,                 80'h0000_0000_0000_0008_1250, 3'd1, 4'h5, 4'h0, 4'h1, 4'h2, 64'h8,   64'h5A,  64'h5A};
        drive(64'h0, 80'h0, 1'b0, 1'b0, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        check("reset.predPC", bus.F_predPC, 64'h0);
        check_d("reset", nop_e);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(v[i].pc, v[i].data, 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("v%0d.imem_addr", i), bus.imem_addr, v[i].pc);
            step();
            check($sformatf("v%0d.predPC", i), bus.F_predPC, v[i].pred);
            check_d($sformatf("v%0d", i), v[i]);
        end

        drive(v[1].pc, v[1].data, 1'b1, 1'b1, 1'b0);
        step();
        drive(v[2].pc, v[2].data, 1'b1, 1'b1, 1'b0);
        step();
        check("stall.predPC", bus.F_predPC, v[10].pred);
        check_d("stall", v[10]);

        drive(v[1].pc, v[1].data, 1'b0, 1'b1, 1'b1);
        step();
        check("stallbub.predPC", bus.F_predPC, v[1].pred);
        check_d("stallbub", v[10]);

        drive(v[2].pc, v[2].data, 1'b0, 1'b0, 1'b1);
        step();
        check("bubble.predPC", bus.F_predPC, v[2].pred);
        check_d("bubble", nop_e);

        drive(v[1].pc, v[1].data, 1'b0, 1'b0, 1'b0);
        step();
        check_d("reload", v[1]);
        drive(v[6].pc, v[6].data, 1'b1, 1'b1, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst.predPC", bus.F_predPC, 64'h0);
        check_d("midrst", nop_e);
        step();
        check_d("inrst", nop_e);
        rst_n = 1'b1;

        drive(v[0].pc, v[0].data, 1'b0, 1'b0, 1'b0);
        step();
        check("post.predPC", bus.F_predPC, v[0].pred);
        check_d("post", v[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
